lcd_text_buffer: RTL

//  Upstream feeder for the TextLCD driver: a COLS x ROWS character frame buffer.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_char_ram.sv | 56 +++++
 rtl/lcd_text_buffer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared constants for the LCD text buffer: control codes understood by the
// byte decoder, the printable ASCII window, and the controller state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package lcd_pkg;

  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  // Inclusive bounds of the bytes that are stored into the frame buffer.
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } lcd_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// ---------------------------------------------------------------------------
// lcd_char_ram
// DEPTH x 8 character storage. Every cell resets asynchronously to FILL_CHAR
// so a reset always presents a blank screen without a sweep.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   we, waddr, wdata  single write port, written on the rising edge
//   raddr, rdata      registered read port, 1-cycle latency
// A read and write of the same cell in one cycle returns the old contents.
// ---------------------------------------------------------------------------
module lcd_char_ram #(
  parameter int         DEPTH     = 32,
  parameter int         AW        = 5,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Read samples the pre-write array, giving read-before-write behaviour.
  always_comb begin
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= FILL_CHAR;
      end
      rdata_q <= FILL_CHAR;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lcd_text_buffer.sv
// ---------------------------------------------------------------------------
// lcd_text_buffer
// COLS x ROWS character frame buffer feeding the TextLCD driver. Decodes a
// host byte stream (printable ASCII, LF, BS, FF), tracks the cursor with line
// wrap, and flags the screen dirty until the LCD stage acknowledges a refresh.
// Ports:
//   clk, resetn              clock, asynchronous reset (active HIGH)
//   in_valid/in_ready/in_char host byte stream
//   rd_row, rd_col, rd_char  registered cell read port (1-cycle latency)
//   cur_row, cur_col         registered cursor position
//   dirty, refresh_ack       screen-changed flag and its clear
// ---------------------------------------------------------------------------
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int         COLS      = 16,
  parameter int         ROWS      = 2,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_char,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [7:0]              rd_char,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic                    dirty,
  input  logic                    refresh_ack
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int AW    = RW + CW;
  localparam int DEPTH = COLS * ROWS;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // Because COLS and ROWS are powers of two, the flat cell index {row, col}
  // equals row*COLS+col, so advancing/retreating the cursor with line wrap
  // and screen wrap is a plain AW-bit increment/decrement.
  lcd_state_t    state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          dirty_q, dirty_d;

  logic          fire;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [RW-1:0] row_next;

  assign in_ready = (state_q == S_IDLE);
  assign fire     = in_valid && in_ready;
  assign row_next = cur_q[AW-1:CW] + RW'(1);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fire && (in_char == CH_FF)) state_d = S_CLEAR;
      S_CLEAR: if (clr_idx_q == LAST_IDX)      state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_d     = cur_q;
    clr_idx_d = clr_idx_q;
    we        = 1'b0;
    waddr     = cur_q;
    wdata     = FILL_CHAR;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (is_printable(in_char)) begin
            we    = 1'b1;
            wdata = in_char;
            cur_d = cur_q + AW'(1);
          end else if (in_char == CH_LF) begin
            cur_d = {row_next, CW'(0)};
          end else if (in_char == CH_BS) begin
            if (cur_q != '0) begin
              we    = 1'b1;
              waddr = cur_q - AW'(1);
              cur_d = cur_q - AW'(1);
            end
          end else if (in_char == CH_FF) begin
            clr_idx_d = '0;
          end
        end
      end
      S_CLEAR: begin
        we        = 1'b1;
        waddr     = clr_idx_q;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          cur_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Any cell write sets dirty and overrides a coincident refresh_ack.
  always_comb begin
    dirty_d = dirty_q;
    if (refresh_ack) dirty_d = 1'b0;
    if (we)          dirty_d = 1'b1;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cur_q     <= '0;
      clr_idx_q <= '0;
      dirty_q   <= 1'b1;
    end else begin
      cur_q     <= cur_d;
      clr_idx_q <= clr_idx_d;
      dirty_q   <= dirty_d;
    end
  end

  lcd_char_ram #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .FILL_CHAR (FILL_CHAR)
  ) u_ram (
    .clk   (clk),
    .rst   (resetn),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr ({rd_row, rd_col}),
    .rdata (rd_char)
  );

  assign cur_row = cur_q[AW-1:CW];
  assign cur_col = cur_q[CW-1:0];
  assign dirty   = dirty_q;

endmodule
